// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the DE10-Lite SDRAM controller.
//   - SDRAM command encodings as {cs_n, ras_n, cas_n, we_n}
//   - A10_ALL: address word selecting all banks for PRECHARGE
//   - ref_state_t: refresh scheduler FSM state type
//   - max_int: elaboration-time helper for sizing counters
package sdram_pkg;

  localparam logic [3:0]  CMD_NOP       = 4'b0111;
  localparam logic [3:0]  CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0]  CMD_REFRESH   = 4'b0001;

  localparam logic [12:0] A10_ALL = 13'h0400;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PALL     = 3'd1,
    ST_PALL_NOP = 3'd2,
    ST_REF      = 3'd3,
    ST_REF_NOP  = 3'd4
  } ref_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_parallel_counter.sv
// sync_parallel_counter: synchronous up-counter with parallel output.
//   clock  : rising-edge clock
//   clear  : synchronous clear to zero (dominates enable)
//   enable : count up by one when high
//   count  : current value (wraps at 2**WIDTH)
module sync_parallel_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// sdram_refresh_scheduler: autonomous SDRAM refresh engine.
// A free-running interval timer accrues refresh debt (capped at
// MAX_POSTPONE). While debt is owed the engine requests the command bus;
// once granted it issues an optional PRECHARGE ALL and then up to REF_BURST
// AUTO REFRESH commands, honouring tRP and tRC with NOPs.
//
// Handshake: ref_req is the request, ref_grant the answer. A service
// starts on a rising edge where the FSM is IDLE and both are high; from
// the next cycle ref_busy holds the command bus until the cycle after the
// ref_done pulse. ref_grant is ignored in every other state, so dropping it
// mid-service does not abort the service.
//
// Ports:
//   clock, reset_n      : clock, synchronous active-low reset
//   ref_grant           : bus grant from the main controller
//   ref_req/ref_urgent  : debt > 0 / debt at ceiling
//   ref_busy/ref_done   : engine owns the bus / end-of-service pulse
//   ref_overrun         : sticky, a tick was lost at the ceiling
//   ref_debt            : current debt
//   dram_*              : command, bank and address pins
//   debug_state         : current FSM state
module sdram_refresh_scheduler
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 1560,
  parameter int REF_BURST    = 1,
  parameter int MAX_POSTPONE = 8,
  parameter int T_RP         = 2,
  parameter int T_RC         = 9,
  parameter bit SKIP_PALL    = 1'b0
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              ref_grant,
  output logic                              ref_req,
  output logic                              ref_urgent,
  output logic                              ref_busy,
  output logic                              ref_done,
  output logic                              ref_overrun,
  output logic [$clog2(MAX_POSTPONE+1)-1:0] ref_debt,
  output logic [12:0]                       dram_addr,
  output logic [1:0]                        dram_ba,
  output logic                              dram_cs_n,
  output logic                              dram_ras_n,
  output logic                              dram_cas_n,
  output logic                              dram_we_n,
  output ref_state_t                        debug_state
);

  localparam int DEBT_W = $clog2(MAX_POSTPONE + 1);
  localparam int TW     = $clog2(REF_INTERVAL);
  localparam int NW     = $clog2(REF_BURST + 1);
  localparam int CW     = $clog2(max_int(T_RP, T_RC)) + 1;

  localparam logic [TW-1:0]     TIMER_RELOAD = TW'(REF_INTERVAL - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX     = DEBT_W'(MAX_POSTPONE);
  // Last counter value of each NOP gap (the gap is T_x - 1 cycles long).
  localparam logic [CW-1:0]     RP_LAST      = CW'((T_RP >= 2) ? (T_RP - 2) : 0);
  localparam logic [CW-1:0]     RC_LAST      = CW'(T_RC - 2);

  if (REF_INTERVAL < 2) begin : g_bad_interval
    $error("REF_INTERVAL must be at least 2");
  end
  if (REF_BURST < 1) begin : g_bad_burst
    $error("REF_BURST must be at least 1");
  end
  if (MAX_POSTPONE < REF_BURST) begin : g_bad_postpone
    $error("MAX_POSTPONE must be at least REF_BURST");
  end
  if (T_RP < 1) begin : g_bad_trp
    $error("T_RP must be at least 1");
  end
  if (T_RC < 2) begin : g_bad_trc
    $error("T_RC must be at least 2");
  end

  ref_state_t        state;
  logic [TW-1:0]     timer;
  logic              tick;
  logic [DEBT_W-1:0] debt;
  logic              overrun;
  logic [NW-1:0]     burst_left;
  logic [NW-1:0]     burst_take;
  logic [CW-1:0]     nop_count;
  logic              refresh_now;
  logic              nop_last;
  logic [3:0]        cmd;

  // ---------------- interval timer: never pauses ----------------
  assign tick = (timer == '0);

  always_ff @(posedge clock) begin
    if (!reset_n || tick) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - TW'(1);
    end
  end

  // ---------------- refresh debt ----------------
  assign refresh_now = (state == ST_REF);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      debt    <= '0;
      overrun <= 1'b0;
    end else if (tick && !refresh_now) begin
      if (debt == DEBT_MAX) begin
        overrun <= 1'b1;
      end else begin
        debt <= debt + DEBT_W'(1);
      end
    end else if (!tick && refresh_now) begin
      debt <= debt - DEBT_W'(1);
    end
    // tick together with REFRESH cancels out: debt unchanged
  end

  // Burst size for this grant; debt accrued later waits for the next grant.
  always_comb begin
    burst_take = NW'(REF_BURST);
    if (int'(debt) < REF_BURST) begin
      burst_take = NW'(debt);
    end
  end

  // ---------------- NOP gap counter ----------------
  sync_parallel_counter #(
    .WIDTH (CW)
  ) u_nop_counter (
    .clock  (clock),
    .clear  (!reset_n || state == ST_PALL || state == ST_REF),
    .enable (state == ST_PALL_NOP || state == ST_REF_NOP),
    .count  (nop_count)
  );

  assign nop_last = (nop_count == RC_LAST);

  // ---------------- service FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      burst_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ref_grant && ref_req) begin
            burst_left <= burst_take;
            state      <= SKIP_PALL ? ST_REF : ST_PALL;
          end
        end
        ST_PALL: begin
          // With T_RP == 1 there is no NOP gap after PRECHARGE.
          state <= (T_RP > 1) ? ST_PALL_NOP : ST_REF;
        end
        ST_PALL_NOP: begin
          if (nop_count == RP_LAST) begin
            state <= ST_REF;
          end
        end
        ST_REF: begin
          burst_left <= burst_left - NW'(1);
          state      <= ST_REF_NOP;
        end
        ST_REF_NOP: begin
          if (nop_last) begin
            state <= (burst_left != '0) ? ST_REF : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- Moore outputs ----------------
  always_comb begin
    cmd = CMD_NOP;
    case (state)
      ST_PALL: cmd = CMD_PRECHARGE;
      ST_REF:  cmd = CMD_REFRESH;
      default: cmd = CMD_NOP;
    endcase
  end

  assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = cmd;
  assign dram_addr   = A10_ALL;
  assign dram_ba     = 2'b00;
  assign ref_busy    = (state != ST_IDLE);
  assign ref_done    = (state == ST_REF_NOP) && nop_last && (burst_left == '0);
  assign ref_req     = (debt != '0);
  assign ref_urgent  = (debt == DEBT_MAX);
  assign ref_overrun = overrun;
  assign ref_debt    = debt;
  assign debug_state = state;

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
module tb_sdram_refresh_scheduler;
  import sdram_pkg::*;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  // Default-parameter service, debt 1: {ref_done, cs_n, ras_n, cas_n, we_n}
  localparam logic [4:0] SVC_A [11] = '{
    {1'b0, PRE}, {1'b0, NOP}, {1'b0, REF},
    {1'b0, NOP}, {1'b0, NOP}, {1'b0, NOP}, {1'b0, NOP},
    {1'b0, NOP}, {1'b0, NOP}, {1'b0, NOP}, {1'b1, NOP}
  };

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n_a, grant_a, reset_n_b, grant_b;
  logic req_a, urgent_a, busy_a, done_a, overrun_a;
  logic req_b, urgent_b, busy_b, done_b, overrun_b;
  logic [3:0] debt_a, debt_b;
  logic [12:0] addr_a, addr_b;
  logic [1:0] ba_a, ba_b;
  logic cs_a, ras_a, cas_a, we_a, cs_b, ras_b, cas_b, we_b;
  ref_state_t dbg_a, dbg_b;
  logic [3:0] cmd_a, cmd_b;
  assign cmd_a = {cs_a, ras_a, cas_a, we_a};
  assign cmd_b = {cs_b, ras_b, cas_b, we_b};

  sdram_refresh_scheduler u_dut_a (
    .clock(clock), .reset_n(reset_n_a), .ref_grant(grant_a),
    .ref_req(req_a), .ref_urgent(urgent_a), .ref_busy(busy_a), .ref_done(done_a),
    .ref_overrun(overrun_a), .ref_debt(debt_a), .dram_addr(addr_a), .dram_ba(ba_a),
    .dram_cs_n(cs_a), .dram_ras_n(ras_a), .dram_cas_n(cas_a), .dram_we_n(we_a),
    .debug_state(dbg_a)
  );

  sdram_refresh_scheduler #(.REF_BURST(4), .SKIP_PALL(1'b1)) u_dut_b (
    .clock(clock), .reset_n(reset_n_b), .ref_grant(grant_b),
    .ref_req(req_b), .ref_urgent(urgent_b), .ref_busy(busy_b), .ref_done(done_b),
    .ref_overrun(overrun_b), .ref_debt(debt_b), .dram_addr(addr_b), .dram_ba(ba_b),
    .dram_cs_n(cs_b), .dram_ras_n(ras_b), .dram_cas_n(cas_b), .dram_we_n(we_b),
    .debug_state(dbg_b)
  );

  // Cycle 1 is the first cycle after the edge that sampled reset low.
  int cyc_a = 0, cyc_b = 0;
  always @(posedge clock) cyc_a <= !reset_n_a ? 1 : cyc_a + 1;
  always @(posedge clock) cyc_b <= !reset_n_b ? 1 : cyc_b + 1;

  int checks = 0, errors = 0;
  logic [4:0] exp_q_a[$], exp_q_b[$];
  logic [4:0] exp_a, exp_b;
  bit mon_a_en = 0, mon_b_en = 0, b_finished = 0;
  int busy_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic at_cycle_a(input int c);
    @(negedge clock);
    while (cyc_a < c) @(negedge clock);
  endtask

  task automatic at_cycle_b(input int c);
    @(negedge clock);
    while (cyc_b < c) @(negedge clock);
  endtask

  task automatic push_default_service_a();
    foreach (SVC_A[i]) exp_q_a.push_back(SVC_A[i]);
  endtask

  // SKIP_PALL service on instance B: n x (REFRESH + 8 NOP), done on the last NOP
  task automatic push_burst_b(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q_b.push_back({1'b0, REF});
      for (int i = 0; i < 8; i++) exp_q_b.push_back({(k == n - 1) && (i == 7), NOP});
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clock) begin
    if (mon_a_en) begin
      if (busy_a || done_a) begin
        checks++;
        if (exp_q_a.size() == 0) begin
          errors++;
          $display("FAIL svc_a_extra: done/cmd=%b, required no service activity", {done_a, cmd_a});
        end else begin
          exp_a = exp_q_a.pop_front();
          if ({done_a, cmd_a} !== exp_a) begin
            errors++;
            $display("FAIL svc_a_seq: done/cmd=%b, required %b", {done_a, cmd_a}, exp_a);
          end
        end
        check("svc_a_addr_ba", {ba_a, addr_a}, {2'b00, 13'h0400});
      end else begin
        check("idle_a_nop", cmd_a, NOP);
      end
    end
  end

  always @(negedge clock) begin
    if (mon_b_en) begin
      if (busy_b) busy_cnt_b++;
      if (busy_b || done_b) begin
        checks++;
        if (exp_q_b.size() == 0) begin
          errors++;
          $display("FAIL svc_b_extra: done/cmd=%b, required no service activity", {done_b, cmd_b});
        end else begin
          exp_b = exp_q_b.pop_front();
          if ({done_b, cmd_b} !== exp_b) begin
            errors++;
            $display("FAIL svc_b_seq: done/cmd=%b, required %b", {done_b, cmd_b}, exp_b);
          end
        end
      end else begin
        check("idle_b_nop", cmd_b, NOP);
      end
    end
  end

  // ---------------- instance B: burst of 3 without PRECHARGE ----------------
  initial begin
    reset_n_b = 1'b0;
    grant_b   = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n_b = 1'b1;
    mon_b_en = 1;
    at_cycle_b(4680);
    check("b_debt_before_third_tick", debt_b, 2);
    at_cycle_b(4681);
    check("b_debt_three", debt_b, 3);
    grant_b = 1'b1;
    busy_cnt_b = 0;
    push_burst_b(3);
    at_cycle_b(4682);
    grant_b = 1'b0;
    at_cycle_b(4709);
    check("b_busy_after", busy_b, 0);
    check("b_debt_after", debt_b, 0);
    check("b_service_len", busy_cnt_b, 27);
    check("b_queue_drained", exp_q_b.size(), 0);
    b_finished = 1;
  end

  // ---------------- instance A: main sequence and report ----------------
  initial begin
    bit quiet_bad;
    reset_n_a = 1'b0;
    grant_a   = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n_a = 1'b1;
    mon_a_en = 1;

    // reset state
    at_cycle_a(1);
    check("rst_req", req_a, 0);
    check("rst_urgent", urgent_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_overrun", overrun_a, 0);
    check("rst_debt", debt_a, 0);
    check("rst_state", dbg_a, ST_IDLE);

    // first interval: quiet, and a grant with no debt is ignored
    quiet_bad = 0;
    for (int k = 2; k <= 1560; k++) begin
      at_cycle_a(k);
      if (req_a || busy_a) quiet_bad = 1;
      if (k == 100) grant_a = 1'b1;
      if (k == 111) grant_a = 1'b0;
    end
    check("first_interval_quiet", quiet_bad, 0);
    at_cycle_a(1561);
    check("first_tick_req", req_a, 1);
    check("first_tick_debt", debt_a, 1);

    // default service; grant held past the end must not retrigger
    grant_a = 1'b1;
    push_default_service_a();
    at_cycle_a(1573);
    check("svc_a_idle_after", busy_a, 0);
    check("svc_a_debt_after", debt_a, 0);
    check("svc_a_queue_drained", exp_q_a.size(), 0);
    at_cycle_a(1574);
    check("svc_a_grant_no_req", busy_a, 0);
    grant_a = 1'b0;

    // withhold grant: debt climbs to the ceiling, then overruns
    at_cycle_a(12481);
    check("debt_seven", debt_a, 7);
    check("urgent_below_ceiling", urgent_a, 0);
    at_cycle_a(14041);
    check("debt_ceiling", debt_a, 8);
    check("urgent_at_ceiling", urgent_a, 1);
    check("no_overrun_yet", overrun_a, 0);
    at_cycle_a(15601);
    check("debt_saturated", debt_a, 8);
    check("overrun_set", overrun_a, 1);

    // REFRESH lands on the tick at cycle 17160: debt unchanged
    at_cycle_a(17157);
    grant_a = 1'b1;
    push_default_service_a();
    at_cycle_a(17158);
    grant_a = 1'b0;
    at_cycle_a(17161);
    check("tick_with_refresh_debt", debt_a, 8);
    at_cycle_a(17169);
    check("svc2_idle_after", busy_a, 0);
    check("svc2_debt_after", debt_a, 8);
    check("svc2_queue_drained", exp_q_a.size(), 0);
    check("overrun_sticky", overrun_a, 1);

    // reset during REF_NOP (REFRESH at 17203, reset sampled at end of 17206)
    at_cycle_a(17200);
    grant_a = 1'b1;
    push_default_service_a();
    at_cycle_a(17201);
    grant_a = 1'b0;
    at_cycle_a(17206);
    check("pre_reset_busy", busy_a, 1);
    reset_n_a = 1'b0;
    @(posedge clock);
    #1 exp_q_a.delete();
    at_cycle_a(1);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_cmd", cmd_a, NOP);
    check("mid_rst_debt", debt_a, 0);
    check("mid_rst_overrun", overrun_a, 0);
    reset_n_a = 1'b1;
    at_cycle_a(1560);
    check("timer_restart_no_req", req_a, 0);
    at_cycle_a(1561);
    check("timer_restart_req", req_a, 1);
    check("timer_restart_debt", debt_a, 1);

    // instance B finishes long before this point
    for (int i = 0; i < 1000 && !b_finished; i++) @(negedge clock);
    check("b_sequence_finished", b_finished, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
